adder_tree_ctrl: RTL and testbench
==================================

# adder_tree_ctrl

Sequencing controller for the 128-input pipelined adder tree in the matmul datapath. It paces PE_result vectors into the tree with a valid/ready handshake and tracks each vector through the tree latency with a tag pipeline. It accumulates the tree outputs of several 128-wide chunks into one dot-product result per row and delivers the results through a small output FIFO with backpressure. The tree itself is outside this block: the controller gates its input and consumes its output.

## Interface
- DATA_WIDTH, 16, width of tree output, accumulator and result
- TREE_LAT, 7, cycles from tree input acceptance to tree_sum valid
- CNT_WIDTH, 8, width of row/chunk configuration and counters
- FIFO_DEPTH, 4, output result FIFO entries (power of 2)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle job start; honoured only in IDLE
- cfg_rows  in  CNT_WIDTH  rows (results) per job, sampled on start
- cfg_chunks  in  CNT_WIDTH  128-wide chunks per row, sampled on start; 0 treated as 1
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse at job completion
- vec_valid  in  1  upstream PE_result vector present on tree input bus
- vec_ready  out  1  controller accepts vector; acceptance = vec_valid & vec_ready
- tree_sum  in  DATA_WIDTH  adder tree output
- out_data  out  DATA_WIDTH  FIFO head result
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  downstream pops head when out_valid & out_ready

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE → RUN: on start with cfg_rows ≠ 0. Latch the configuration, clear the row and chunk counters, assert busy.
- IDLE with start and cfg_rows = 0: pulse done in the next cycle and stay in IDLE.
- start in RUN or DRAIN is ignored.
- RUN: each accepted vector is one chunk. The chunk counter advances per acceptance. When it wraps at cfg_chunks, the row counter advances.
- RUN → DRAIN: on acceptance of the last chunk of the last row.
- DRAIN → IDLE: when the tag pipeline holds no valid entry and the FIFO is empty (last result popped). done pulses in the first IDLE cycle. busy drops in the same cycle.
- Tag pipeline: TREE_LAT-stage shift register of {valid, first, last}. A tag is inserted on each acceptance. first marks chunk index 0 of a row; last marks chunk index cfg_chunks−1 (both are set when cfg_chunks = 1).
- Tag at pipeline output with valid set, using tree_sum:
  - sum = first ? tree_sum : acc + tree_sum, modulo 2^DATA_WIDTH (two's-complement wrap, no saturation).
  - acc ← sum.
  - if last, push sum into the FIFO.
- Credit rule: the first chunk of a row is accepted only if fifo_count + rows_in_flight < FIFO_DEPTH.
  - rows_in_flight counts rows whose first chunk was accepted but whose result has not yet been pushed.
  - Non-first chunks need no credit.
  - This guarantees the FIFO never overflows, since the tree cannot stall.
- vec_ready = (state == RUN) & (not at a first chunk, or credit available). It never depends on vec_valid.
- FIFO push and pop in the same cycle are both performed, so occupancy is unchanged. Pop on empty cannot occur because out_valid is low.
- Results leave in row order.
- rst at any time:
  - state ← IDLE; counters, acc, tag pipeline and FIFO cleared.
  - Tree results still in flight are discarded.

## Timing
- Reset values: busy 0, done 0, vec_ready 0, out_valid 0, out_data 0.
- A chunk accepted in cycle t has its tree_sum sampled in cycle t+TREE_LAT.
- A last-chunk result pushed at the end of cycle t+TREE_LAT shows out_valid and out_data from cycle t+TREE_LAT+1 (8 cycles after acceptance at default).
- Throughput is 1 chunk/cycle while vec_valid is high and credit exists.
- Gaps in vec_valid insert bubbles only; accumulation is unaffected.
- done is asserted for exactly one cycle; out_data is registered (FIFO head).

## Test plan
- Reset: assert rst 2 cycles mid-stream → all outputs 0, vec_ready 0. No out_valid appears for the pre-reset chunks even when their tree latency elapses.
- cfg_rows=3, cfg_chunks=1, vec_valid=1, out_ready=1, tree_sum model = 0x0011, 0x0022, 0x0033 → vec_ready high 3 cycles. out_data 0x0011/0x0022/0x0033 at acceptance+8. done pulses once after the last pop.
- cfg_rows=2, cfg_chunks=4, tree sums 1, 2, 3, 4, 0x7FFF, 1, 0, 0 → results 0x000A then 0x8000 (wrap).
- Backpressure: out_ready=0, cfg_rows=6, cfg_chunks=1 → exactly 4 acceptances, then vec_ready held 0. Raising out_ready resumes issue; 6 results are delivered in order; no loss or duplication.
- cfg_chunks=3 with vec_valid toggled 1,0,1,0,1 and sums 5, 6, 7 → single result 0x0012. Bubbles are not counted as chunks.
- cfg_rows=0 start → done pulse the next cycle, busy stays 0. A start issued during RUN is ignored, so the job's row count is unchanged.

Source files
------------

// File: rtl/adder_tree_ctrl.sv
// Sequencing controller for the 128-input pipelined adder tree: paces chunk vectors in,
// tracks them through the tree latency, accumulates per-row results into an output FIFO.
module adder_tree_ctrl #(
   parameter int DATA_WIDTH = 16,
   parameter int TREE_LAT   = 7,
   parameter int CNT_WIDTH  = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [CNT_WIDTH-1:0]  cfg_rows,
   input  logic [CNT_WIDTH-1:0]  cfg_chunks,
   output logic                  busy,
   output logic                  done,
   input  logic                  vec_valid,
   output logic                  vec_ready,
   input  logic [DATA_WIDTH-1:0] tree_sum,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                state;
   logic [CNT_WIDTH-1:0]  rows_cfg, chunks_cfg, row_cnt, chunk_cnt;
   logic [TREE_LAT-1:0]   tag_valid, tag_first, tag_last;
   logic [DATA_WIDTH-1:0] acc, sum;
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]         rd_ptr, wr_ptr;
   logic [CW-1:0]         fifo_count, rows_in_flight;
   logic [CW:0]           occupancy;
   logic                  at_first, is_last_chunk, is_last_row, credit;
   logic                  accept, out_tag, push, pop;

   // A row needs a FIFO slot reserved before its first chunk enters, since the tree never stalls.
   always_comb begin
      at_first      = (chunk_cnt == '0);
      is_last_chunk = (chunk_cnt == chunks_cfg - CNT_WIDTH'(1));
      is_last_row   = (row_cnt == rows_cfg - CNT_WIDTH'(1));
      occupancy     = {1'b0, fifo_count} + {1'b0, rows_in_flight};
      credit        = (occupancy < DEPTH_L);
      vec_ready     = (state == RUN) && (!at_first || credit);
      accept        = vec_valid && vec_ready;
      out_tag       = tag_valid[TREE_LAT-1];
      sum           = tag_first[TREE_LAT-1] ? tree_sum : acc + tree_sum;
      push          = out_tag && tag_last[TREE_LAT-1];
      out_valid     = (fifo_count != '0);
      pop           = out_valid && out_ready;
      out_data      = mem[rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         rows_cfg   <= '0;
         chunks_cfg <= '0;
         row_cnt    <= '0;
         chunk_cnt  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (cfg_rows == '0) begin
                     done <= 1'b1;
                  end else begin
                     rows_cfg   <= cfg_rows;
                     chunks_cfg <= (cfg_chunks == '0) ? CNT_WIDTH'(1) : cfg_chunks;
                     row_cnt    <= '0;
                     chunk_cnt  <= '0;
                     busy       <= 1'b1;
                     state      <= RUN;
                  end
               end
            end
            RUN: begin
               if (accept) begin
                  if (is_last_chunk) begin
                     chunk_cnt <= '0;
                     row_cnt   <= row_cnt + CNT_WIDTH'(1);
                     if (is_last_row) state <= DRAIN;
                  end else begin
                     chunk_cnt <= chunk_cnt + CNT_WIDTH'(1);
                  end
               end
            end
            DRAIN: begin
               if (tag_valid == '0 && fifo_count == '0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tag_valid <= '0;
         tag_first <= '0;
         tag_last  <= '0;
         acc       <= '0;
      end else begin
         tag_valid <= {tag_valid[TREE_LAT-2:0], accept};
         tag_first <= {tag_first[TREE_LAT-2:0], accept && at_first};
         tag_last  <= {tag_last[TREE_LAT-2:0], accept && is_last_chunk};
         if (out_tag) acc <= sum;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr         <= '0;
         wr_ptr         <= '0;
         fifo_count     <= '0;
         rows_in_flight <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= sum;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
         case ({accept && at_first, push})
            2'b10:   rows_in_flight <= rows_in_flight + CW'(1);
            2'b01:   rows_in_flight <= rows_in_flight - CW'(1);
            default: rows_in_flight <= rows_in_flight;
         endcase
      end
   end

endmodule

// File: tb/tb_adder_tree_ctrl.sv
// Self-checking bench for adder_tree_ctrl: models the external tree as a fixed delay line
// and predicts per-row dot-product results from the chunk sums with plain arithmetic.
module tb_adder_tree_ctrl;

   localparam int DW = 16;
   localparam int TL = 7;
   localparam int CW = 8;
   localparam int FD = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [CW-1:0] cfg_rows = '0, cfg_chunks = '0;
   logic          busy, done, vec_ready, out_valid;
   logic          vec_valid = 1'b0;
   logic          out_ready = 1'b1;
   logic [DW-1:0] tree_sum, out_data;
   logic [DW-1:0] vec_sum = '0;

   adder_tree_ctrl #(.DATA_WIDTH(DW), .TREE_LAT(TL), .CNT_WIDTH(CW), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .rst(rst), .start(start), .cfg_rows(cfg_rows), .cfg_chunks(cfg_chunks),
      .busy(busy), .done(done), .vec_valid(vec_valid), .vec_ready(vec_ready),
      .tree_sum(tree_sum), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   int tests_run = 0;
   int failed = 0;
   int cyc = 0;
   int rdy_cnt = 0;
   int ov_cnt = 0;
   int unsigned   vq[$];
   int unsigned   src[$];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] got_q[$];
   int            acc_t[$], got_t[$], done_t[$];
   logic          acc_now = 1'b0;
   logic [DW-1:0] acc_val = '0;
   logic [DW-1:0] pipe [TL];
   logic          gap_mode = 1'b0, tgl = 1'b0, rand_ready = 1'b0, ready_level = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   // External tree: the vector accepted in cycle t comes back as tree_sum in cycle t+TL.
   always @(posedge clk) begin
      for (int i = TL - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= acc_now ? acc_val : '0;
   end
   assign tree_sum = pipe[TL-1];

   always @(posedge clk) begin
      #2;
      tgl       = ~tgl;
      vec_valid = (vq.size() > 0) && (!gap_mode || tgl);
      vec_sum   = (vq.size() > 0) ? vq[0][DW-1:0] : '0;
      out_ready = rand_ready ? 1'($urandom) : ready_level;
   end

   always @(negedge clk) begin
      acc_now = 1'b0;
      if (!rst) begin
         if (vec_valid && vec_ready) begin
            acc_now = 1'b1;
            acc_val = vec_sum;
            acc_t.push_back(cyc);
            if (vq.size() > 0) void'(vq.pop_front());
         end
         if (out_valid && out_ready) begin
            got_q.push_back(out_data);
            got_t.push_back(cyc);
         end
         if (done) done_t.push_back(cyc);
         if (vec_ready) rdy_cnt++;
         if (out_valid) ov_cnt++;
      end
   end

   task automatic clear_logs();
      acc_t.delete(); got_q.delete(); got_t.delete(); done_t.delete();
      rdy_cnt = 0;
      ov_cnt  = 0;
   endtask

   task automatic rand_src(int n);
      src.delete();
      for (int i = 0; i < n; i++) src.push_back($urandom_range(0, 32'hFFFF));
   endtask

   // Reference: each row's result is the wrapped sum of its chunk sums.
   task automatic load_job(int rows, int chunks);
      int ch = (chunks == 0) ? 1 : chunks;
      logic [DW-1:0] s;
      exp_q.delete();
      for (int r = 0; r < rows; r++) begin
         s = '0;
         for (int c = 0; c < ch; c++) begin
            s += src[r*ch + c][DW-1:0];
            vq.push_back(src[r*ch + c]);
         end
         exp_q.push_back(s);
      end
   endtask

   task automatic start_job(int rows, int chunks);
      @(posedge clk); #1;
      cfg_rows   = CW'(rows);
      cfg_chunks = CW'(chunks);
      start      = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk); #1;
         if (done_t.size() > 0) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      clear_logs();
      rand_src(8);
      load_job(4, 2);
      start_job(4, 2);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      vq.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      tests_run++; if (acc_t.size() !== 4) begin failed++; $display("FAIL reset_pre_accepts got %0d want 4", acc_t.size()); end
      tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy got %b want 0", busy); end
      tests_run++; if (done !== 1'b0) begin failed++; $display("FAIL reset_done got %b want 0", done); end
      tests_run++; if (vec_ready !== 1'b0) begin failed++; $display("FAIL reset_vec_ready got %b want 0", vec_ready); end
      tests_run++; if (out_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      tests_run++; if (out_data !== '0) begin failed++; $display("FAIL reset_out_data got %h want 0", out_data); end
      ov_cnt = 0;
      repeat (15) @(negedge clk);
      #1;
      tests_run++; if (ov_cnt !== 0) begin failed++; $display("FAIL reset_stale_out_valid got %0d cycles want 0", ov_cnt); end
      tests_run++; if (got_q.size() !== 0) begin failed++; $display("FAIL reset_stale_results got %0d want 0", got_q.size()); end
   endtask

   task automatic test_single_chunk();
      bit ok;
      clear_logs();
      src = '{32'h11, 32'h22, 32'h33};
      load_job(3, 1);
      start_job(3, 1);
      wait_done(200, ok);
      tests_run++; if (!ok) begin failed++; $display("FAIL single_done_timeout got none want done"); end
      tests_run++; if (rdy_cnt !== 3) begin failed++; $display("FAIL single_ready_cycles got %0d want 3", rdy_cnt); end
      tests_run++; if (got_q.size() !== 3) begin failed++; $display("FAIL single_count got %0d want 3", got_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         tests_run++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            failed++; $display("FAIL single_data[%0d] got %h want %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
         end
         tests_run++;
         if (i >= got_t.size() || i >= acc_t.size() || got_t[i] - acc_t[i] !== TL + 1) begin
            failed++; $display("FAIL single_latency[%0d] got %0d want %0d", i,
                               (i < got_t.size() && i < acc_t.size()) ? got_t[i] - acc_t[i] : -1, TL + 1);
         end
      end
      tests_run++; if (done_t.size() !== 1) begin failed++; $display("FAIL single_done_pulses got %0d want 1", done_t.size()); end
      tests_run++;
      if (done_t.size() < 1 || got_t.size() < 3 || done_t[0] !== got_t[2] + 2) begin
         failed++; $display("FAIL single_done_timing got %0d want %0d",
                            (done_t.size() > 0) ? done_t[0] : -1, (got_t.size() > 2) ? got_t[2] + 2 : -1);
      end
   endtask

   task automatic test_accumulate();
      bit ok;
      clear_logs();
      src = '{32'd1, 32'd2, 32'd3, 32'd4, 32'h7FFF, 32'd1, 32'd0, 32'd0};
      load_job(2, 4);
      start_job(2, 4);
      wait_done(200, ok);
      tests_run++; if (!ok) begin failed++; $display("FAIL accum_done_timeout got none want done"); end
      tests_run++; if (got_q.size() !== 2) begin failed++; $display("FAIL accum_count got %0d want 2", got_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         tests_run++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            failed++; $display("FAIL accum_data[%0d] got %h want %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
         end
      end
      tests_run++;
      if (got_t.size() < 2 || acc_t.size() < 8 || got_t[1] - acc_t[7] !== TL + 1) begin
         failed++; $display("FAIL accum_latency got %0d want %0d",
                            (got_t.size() > 1 && acc_t.size() > 7) ? got_t[1] - acc_t[7] : -1, TL + 1);
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      ready_level = 1'b0;
      @(posedge clk);
      clear_logs();
      rand_src(6);
      load_job(6, 1);
      start_job(6, 1);
      repeat (20) @(negedge clk);
      #1;
      tests_run++; if (acc_t.size() !== FD) begin failed++; $display("FAIL bp_accepts got %0d want %0d", acc_t.size(), FD); end
      tests_run++; if (vec_ready !== 1'b0) begin failed++; $display("FAIL bp_ready_held got %b want 0", vec_ready); end
      tests_run++; if (out_valid !== 1'b1) begin failed++; $display("FAIL bp_out_valid got %b want 1", out_valid); end
      tests_run++; if (out_data !== exp_q[0]) begin failed++; $display("FAIL bp_head got %h want %h", out_data, exp_q[0]); end
      ready_level = 1'b1;
      wait_done(300, ok);
      tests_run++; if (!ok) begin failed++; $display("FAIL bp_done_timeout got none want done"); end
      tests_run++; if (acc_t.size() !== 6) begin failed++; $display("FAIL bp_total_accepts got %0d want 6", acc_t.size()); end
      tests_run++; if (got_q.size() !== 6) begin failed++; $display("FAIL bp_count got %0d want 6", got_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         tests_run++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            failed++; $display("FAIL bp_data[%0d] got %h want %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
         end
      end
      tests_run++; if (done_t.size() !== 1) begin failed++; $display("FAIL bp_done_pulses got %0d want 1", done_t.size()); end
   endtask

   task automatic test_bubbles();
      bit ok;
      gap_mode = 1'b1;
      clear_logs();
      src = '{32'd5, 32'd6, 32'd7};
      load_job(1, 3);
      start_job(1, 3);
      wait_done(200, ok);
      gap_mode = 1'b0;
      tests_run++; if (!ok) begin failed++; $display("FAIL bubble_done_timeout got none want done"); end
      tests_run++; if (acc_t.size() !== 3) begin failed++; $display("FAIL bubble_accepts got %0d want 3", acc_t.size()); end
      tests_run++; if (got_q.size() !== 1) begin failed++; $display("FAIL bubble_count got %0d want 1", got_q.size()); end
      tests_run++;
      if (got_q.size() < 1 || got_q[0] !== exp_q[0]) begin
         failed++; $display("FAIL bubble_data got %h want %h", (got_q.size() > 0) ? got_q[0] : '0, exp_q[0]);
      end
      tests_run++;
      if (acc_t.size() < 3 || acc_t[2] - acc_t[0] !== 4) begin
         failed++; $display("FAIL bubble_spacing got %0d want 4", (acc_t.size() > 2) ? acc_t[2] - acc_t[0] : -1);
      end
   endtask

   task automatic test_zero_rows_and_restart();
      bit ok;
      clear_logs();
      @(posedge clk); #1;
      cfg_rows = '0;
      cfg_chunks = CW'(3);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      tests_run++; if (done !== 1'b1) begin failed++; $display("FAIL zero_done got %b want 1", done); end
      tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL zero_busy got %b want 0", busy); end
      @(posedge clk); #1;
      tests_run++; if (done !== 1'b0) begin failed++; $display("FAIL zero_done_width got %b want 0", done); end
      clear_logs();
      rand_src(4);
      load_job(2, 2);
      start_job(2, 2);
      cfg_rows = CW'(5);
      cfg_chunks = CW'(1);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      tests_run++; if (busy !== 1'b1) begin failed++; $display("FAIL restart_busy got %b want 1", busy); end
      wait_done(200, ok);
      tests_run++; if (!ok) begin failed++; $display("FAIL restart_done_timeout got none want done"); end
      tests_run++; if (acc_t.size() !== 4) begin failed++; $display("FAIL restart_accepts got %0d want 4", acc_t.size()); end
      tests_run++; if (got_q.size() !== 2) begin failed++; $display("FAIL restart_count got %0d want 2", got_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         tests_run++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            failed++; $display("FAIL restart_data[%0d] got %h want %h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
         end
      end
   endtask

   task automatic test_random_jobs();
      bit ok;
      int rows, chunks;
      rand_ready = 1'b1;
      for (int j = 0; j < 5; j++) begin
         rows     = $urandom_range(1, 6);
         chunks   = $urandom_range(0, 5);
         gap_mode = 1'($urandom);
         clear_logs();
         rand_src(rows * ((chunks == 0) ? 1 : chunks));
         load_job(rows, chunks);
         start_job(rows, chunks);
         wait_done(3000, ok);
         tests_run++; if (!ok) begin failed++; $display("FAIL rand%0d_done_timeout got none want done", j); end
         tests_run++;
         if (got_q.size() !== exp_q.size()) begin
            failed++; $display("FAIL rand%0d_count got %0d want %0d", j, got_q.size(), exp_q.size());
         end
         for (int i = 0; i < exp_q.size(); i++) begin
            tests_run++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
               failed++; $display("FAIL rand%0d_data[%0d] got %h want %h", j, i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
            end
         end
      end
      rand_ready = 1'b0;
      gap_mode   = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      test_reset();
      test_single_chunk();
      test_accumulate();
      test_backpressure();
      test_bubbles();
      test_zero_rows_and_restart();
      test_random_jobs();
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
